// File: rtl/quad_enc_pkg.sv
// Shared phase encodings, accumulator sizing and decode helpers for the quadrature counter.
// Phase is {A,B} after filtering; idle detent is 11.
package quad_enc_pkg;

  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_01 = 2'b01;

  localparam int ACC_W        = 3;
  localparam int DETENT_STEPS = 4;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_UP,
    EV_DN,
    EV_ERR
  } step_ev_e;

  // Forward rotation has B falling first: 11 -> 10 -> 00 -> 01 -> 11.
  function automatic logic [1:0] next_fwd(input logic [1:0] phase);
    case (phase)
      PH_11:   next_fwd = PH_10;
      PH_10:   next_fwd = PH_00;
      PH_00:   next_fwd = PH_01;
      default: next_fwd = PH_11;
    endcase
  endfunction

endpackage

// File: rtl/enc_pin_filter.sv
// Two-flop synchroniser plus stability filter for one encoder pin; output idles high.
// Latency 2+FILTER_CYCLES clk from first sampling edge; no backpressure.
module enc_pin_filter #(
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          lvl_q, lvl_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    lvl_d = lvl_q;
    cnt_d = cnt_q;
    if (sync2_q == lvl_q) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      lvl_d = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      lvl_q   <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = lvl_q;

endmodule

// File: rtl/quad_enc_counter.sv
// Quadrature decoder: sync/filter, x1 or x4 steps into a modulo count, clr/load, illegal-jump err; no backpressure.
// Latency 3+FILTER_CYCLES clk from pin edge; QUAD_ENC_ERR_CNT_EN adds a saturating err_cnt output.
module quad_enc_counter
  import quad_enc_pkg::*;
#(
  parameter int CNT_W         = 8,
  parameter int MOD_VAL       = 20,
  parameter int FILTER_CYCLES = 4,
  parameter int X4_MODE       = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             step_up,
  output logic             step_dn,
  output logic             dir,
  output logic             err
`ifdef QUAD_ENC_ERR_CNT_EN
  , output logic [7:0]     err_cnt
`endif
);

  localparam int AW = ACC_W + 1;
  localparam logic [CNT_W-1:0]     MAX_C   = CNT_W'(MOD_VAL - 1);
  localparam logic signed [AW-1:0] ACC_LIM = AW'(DETENT_STEPS);

  logic                    af, bf;
  logic [1:0]              ph, ph_q, chg;
  logic                    is_fwd, is_rev;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [AW-1:0]    acc_ext, acc_sum;
  step_ev_e                ev;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    step_up_q, step_up_d, step_dn_q, step_dn_d;
  logic                    dir_q, dir_d, err_q, err_d;

  enc_pin_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_a (
    .clk(clk), .rst_n(rst_n), .din(enc_a), .dout(af)
  );
  enc_pin_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_b (
    .clk(clk), .rst_n(rst_n), .din(enc_b), .dout(bf)
  );

  assign ph = {af, bf};

  always_comb begin
    chg     = ph ^ ph_q;
    is_fwd  = (chg == 2'b01 || chg == 2'b10) && (ph == next_fwd(ph_q));
    is_rev  = (chg == 2'b01 || chg == 2'b10) && (ph_q == next_fwd(ph));
    acc_ext = {acc_q[ACC_W-1], acc_q};
    acc_sum = is_fwd ? acc_ext + AW'(1) : acc_ext - AW'(1);
    ev      = EV_NONE;
    acc_d   = acc_q;
    if (chg == 2'b11) begin
      ev    = EV_ERR;
      acc_d = '0;
    end else if (X4_MODE != 0) begin
      if (is_fwd)      ev = EV_UP;
      else if (is_rev) ev = EV_DN;
    end else if (is_fwd || is_rev) begin
      // Only a full four-edge excursion back to the detent counts; shorter bounces just rearm.
      if (ph == PH_11) begin
        acc_d = '0;
        if (acc_sum == ACC_LIM)       ev = EV_UP;
        else if (acc_sum == -ACC_LIM) ev = EV_DN;
      end else if (acc_sum >= ACC_LIM) begin
        acc_d = ACC_W'(DETENT_STEPS - 1);
      end else if (acc_sum <= -ACC_LIM) begin
        acc_d = ACC_W'(-DETENT_STEPS);
      end else begin
        acc_d = acc_sum[ACC_W-1:0];
      end
    end
  end

  always_comb begin
    count_d   = count_q;
    step_up_d = 1'b0;
    step_dn_d = 1'b0;
    dir_d     = dir_q;
    err_d     = (ev == EV_ERR);
    if (ev == EV_UP) dir_d = 1'b1;
    if (ev == EV_DN) dir_d = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = (load_val > MAX_C) ? MAX_C : load_val;
    end else if (ev == EV_UP) begin
      count_d   = (count_q == MAX_C) ? '0 : count_q + CNT_W'(1);
      step_up_d = 1'b1;
    end else if (ev == EV_DN) begin
      count_d   = (count_q == '0) ? MAX_C : count_q - CNT_W'(1);
      step_dn_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q      <= PH_11;
      acc_q     <= '0;
      count_q   <= '0;
      step_up_q <= 1'b0;
      step_dn_q <= 1'b0;
      dir_q     <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      ph_q      <= ph;
      acc_q     <= acc_d;
      count_q   <= count_d;
      step_up_q <= step_up_d;
      step_dn_q <= step_dn_d;
      dir_q     <= dir_d;
      err_q     <= err_d;
    end
  end

  assign count   = count_q;
  assign step_up = step_up_q;
  assign step_dn = step_dn_q;
  assign dir     = dir_q;
  assign err     = err_q;

`ifdef QUAD_ENC_ERR_CNT_EN
  logic [7:0] ecnt_q, ecnt_d;

  always_comb begin
    ecnt_d = ecnt_q;
    if (clr)                              ecnt_d = '0;
    else if (err_d && ecnt_q != 8'hFF)    ecnt_d = ecnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecnt_q <= '0;
    else        ecnt_q <= ecnt_d;
  end

  assign err_cnt = ecnt_q;
`endif

endmodule

// File: tb/tb_quad_enc_counter.sv
// Directed bench: x1 and x4 instances share the pins and controls, expectations are hand-computed.
module tb_quad_enc_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enc_a = 1'b1, enc_b = 1'b1;
  logic       clr = 1'b0, load = 1'b0;
  logic [7:0] load_val = 8'd0;

  logic [7:0] cnt_x1, cnt_x4;
  logic       sup_x1, sdn_x1, dir_x1, err_x1;
  logic       sup_x4, sdn_x4, dir_x4, err_x4;
`ifdef QUAD_ENC_ERR_CNT_EN
  logic [7:0] ecnt_x1, ecnt_x4;
`endif

  int n_vec = 0, n_miss = 0;
  int n_up_x1 = 0, n_dn_x1 = 0, n_err_x1 = 0;
  int n_up_x4 = 0, n_dn_x4 = 0, n_err_x4 = 0;

  always #5 clk = ~clk;

  quad_enc_counter #(.CNT_W(8), .MOD_VAL(20), .FILTER_CYCLES(4), .X4_MODE(0)) dut (
    .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .clr(clr), .load(load),
    .load_val(load_val), .count(cnt_x1), .step_up(sup_x1), .step_dn(sdn_x1),
    .dir(dir_x1), .err(err_x1)
`ifdef QUAD_ENC_ERR_CNT_EN
    , .err_cnt(ecnt_x1)
`endif
  );

  quad_enc_counter #(.CNT_W(8), .MOD_VAL(20), .FILTER_CYCLES(4), .X4_MODE(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .clr(clr), .load(load),
    .load_val(load_val), .count(cnt_x4), .step_up(sup_x4), .step_dn(sdn_x4),
    .dir(dir_x4), .err(err_x4)
`ifdef QUAD_ENC_ERR_CNT_EN
    , .err_cnt(ecnt_x4)
`endif
  );

  always @(negedge clk) begin
    if (sup_x1 === 1'b1) n_up_x1++;
    if (sdn_x1 === 1'b1) n_dn_x1++;
    if (err_x1 === 1'b1) n_err_x1++;
    if (sup_x4 === 1'b1) n_up_x4++;
    if (sdn_x4 === 1'b1) n_dn_x4++;
    if (err_x4 === 1'b1) n_err_x4++;
  end

  task automatic phase(input logic [1:0] ph, input int n);
    enc_a = ph[1];
    enc_b = ph[0];
    repeat (n) @(negedge clk);
  endtask

  task automatic fwd_detent();
    phase(2'b10, 10); phase(2'b00, 10); phase(2'b01, 10); phase(2'b11, 10);
  endtask

  task automatic rev_detent();
    phase(2'b01, 10); phase(2'b00, 10); phase(2'b10, 10); phase(2'b11, 10);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (cnt_x1 !== 8'd0) begin n_miss++; $display("FAIL reset_cnt_x1: got %0d expected 0", cnt_x1); end
    n_vec++; if (cnt_x4 !== 8'd0) begin n_miss++; $display("FAIL reset_cnt_x4: got %0d expected 0", cnt_x4); end
    n_vec++; if ({sup_x1, sdn_x1, dir_x1, err_x1} !== 4'b0010) begin
      n_miss++; $display("FAIL reset_flags_x1: got %b expected 0010", {sup_x1, sdn_x1, dir_x1, err_x1}); end
`ifdef QUAD_ENC_ERR_CNT_EN
    n_vec++; if (ecnt_x1 !== 8'd0) begin n_miss++; $display("FAIL reset_ecnt: got %0d expected 0", ecnt_x1); end
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_single_detent();
    phase(2'b10, 10); phase(2'b00, 10); phase(2'b01, 10);
    enc_a = 1'b1; enc_b = 1'b1;
    repeat (6) @(negedge clk);
    n_vec++; if ({sup_x1, cnt_x1} !== {1'b0, 8'd0}) begin
      n_miss++; $display("FAIL det_early: got up=%b cnt=%0d expected up=0 cnt=0", sup_x1, cnt_x1); end
    @(negedge clk);
    n_vec++; if ({sup_x1, cnt_x1, dir_x1} !== {1'b1, 8'd1, 1'b1}) begin
      n_miss++; $display("FAIL det_edge7: got up=%b cnt=%0d dir=%b expected up=1 cnt=1 dir=1", sup_x1, cnt_x1, dir_x1); end
    @(negedge clk);
    n_vec++; if (sup_x1 !== 1'b0) begin n_miss++; $display("FAIL det_pulse_width: got up=%b expected 0", sup_x1); end
    repeat (2) @(negedge clk);
    n_vec++; if (cnt_x4 !== 8'd4) begin n_miss++; $display("FAIL det_cnt_x4: got %0d expected 4", cnt_x4); end
  endtask

  task automatic test_wrap();
    int b_up, b_dn;
    b_up = n_up_x1;
    repeat (18) fwd_detent();
    n_vec++; if (cnt_x1 !== 8'd19) begin n_miss++; $display("FAIL wrap_19: got %0d expected 19", cnt_x1); end
    n_vec++; if (cnt_x4 !== 8'd16) begin n_miss++; $display("FAIL wrap_x4_16: got %0d expected 16", cnt_x4); end
    fwd_detent();
    n_vec++; if (cnt_x1 !== 8'd0) begin n_miss++; $display("FAIL wrap_0: got %0d expected 0", cnt_x1); end
    n_vec++; if (n_up_x1 - b_up !== 19) begin n_miss++; $display("FAIL wrap_pulses: got %0d expected 19", n_up_x1 - b_up); end
    b_dn = n_dn_x1;
    rev_detent();
    n_vec++; if ({cnt_x1, dir_x1} !== {8'd19, 1'b0}) begin
      n_miss++; $display("FAIL rev_wrap: got cnt=%0d dir=%b expected cnt=19 dir=0", cnt_x1, dir_x1); end
    n_vec++; if (n_dn_x1 - b_dn !== 1) begin n_miss++; $display("FAIL rev_pulse: got %0d expected 1", n_dn_x1 - b_dn); end
    n_vec++; if (cnt_x4 !== 8'd16) begin n_miss++; $display("FAIL rev_x4: got %0d expected 16", cnt_x4); end
  endtask

  task automatic test_glitch();
    int b1, b4;
    b1 = n_up_x1 + n_dn_x1 + n_err_x1;
    b4 = n_up_x4 + n_dn_x4 + n_err_x4;
    phase(2'b01, 3); phase(2'b11, 12);
    n_vec++; if (n_up_x4 + n_dn_x4 + n_err_x4 - b4 !== 0) begin
      n_miss++; $display("FAIL glitch3_x4: got %0d events expected 0", n_up_x4 + n_dn_x4 + n_err_x4 - b4); end
    n_vec++; if ({cnt_x1, cnt_x4} !== {8'd19, 8'd16}) begin
      n_miss++; $display("FAIL glitch3_cnt: got %0d/%0d expected 19/16", cnt_x1, cnt_x4); end
    b4 = n_dn_x4;
    phase(2'b01, 4); phase(2'b11, 12);
    n_vec++; if (n_dn_x4 - b4 !== 1) begin n_miss++; $display("FAIL glitch4_dn_x4: got %0d expected 1", n_dn_x4 - b4); end
    n_vec++; if (cnt_x4 !== 8'd16) begin n_miss++; $display("FAIL glitch4_cnt_x4: got %0d expected 16", cnt_x4); end
    n_vec++; if (n_up_x1 + n_dn_x1 + n_err_x1 - b1 !== 0 || cnt_x1 !== 8'd19) begin
      n_miss++; $display("FAIL glitch_x1: got %0d events cnt=%0d expected 0 events cnt=19", n_up_x1 + n_dn_x1 + n_err_x1 - b1, cnt_x1); end
  endtask

  task automatic test_illegal();
    int b1, b4;
    b1 = n_err_x1; b4 = n_err_x4;
    phase(2'b00, 10);
    n_vec++; if (n_err_x1 - b1 !== 1) begin n_miss++; $display("FAIL err_x1: got %0d pulses expected 1", n_err_x1 - b1); end
    n_vec++; if (n_err_x4 - b4 !== 1) begin n_miss++; $display("FAIL err_x4: got %0d pulses expected 1", n_err_x4 - b4); end
    n_vec++; if ({cnt_x1, cnt_x4} !== {8'd19, 8'd16}) begin
      n_miss++; $display("FAIL err_cnt_hold: got %0d/%0d expected 19/16", cnt_x1, cnt_x4); end
    phase(2'b01, 10); phase(2'b11, 10);
    n_vec++; if ({cnt_x1, cnt_x4} !== {8'd19, 8'd18}) begin
      n_miss++; $display("FAIL err_recover: got %0d/%0d expected 19/18", cnt_x1, cnt_x4); end
    n_vec++; if (n_err_x1 - b1 !== 1) begin n_miss++; $display("FAIL err_once: got %0d expected 1", n_err_x1 - b1); end
`ifdef QUAD_ENC_ERR_CNT_EN
    n_vec++; if ({ecnt_x1, ecnt_x4} !== {8'd1, 8'd1}) begin
      n_miss++; $display("FAIL err_cnt_val: got %0d/%0d expected 1/1", ecnt_x1, ecnt_x4); end
`endif
  endtask

  task automatic test_x4();
    int b1, b4;
    b1 = n_up_x1; b4 = n_up_x4;
    fwd_detent();
    n_vec++; if (cnt_x4 !== 8'd2) begin n_miss++; $display("FAIL x4_cnt: got %0d expected 2", cnt_x4); end
    n_vec++; if (n_up_x4 - b4 !== 4) begin n_miss++; $display("FAIL x4_pulses: got %0d expected 4", n_up_x4 - b4); end
    n_vec++; if ({cnt_x1, 8'(n_up_x1 - b1)} !== {8'd0, 8'd1}) begin
      n_miss++; $display("FAIL x1_wrap_up: got cnt=%0d pulses=%0d expected 0/1", cnt_x1, n_up_x1 - b1); end
    b1 = n_up_x1 + n_dn_x1;
    phase(2'b10, 10); phase(2'b00, 10); phase(2'b10, 10); phase(2'b11, 10);
    n_vec++; if (cnt_x1 !== 8'd0 || n_up_x1 + n_dn_x1 - b1 !== 0) begin
      n_miss++; $display("FAIL half_detent: got cnt=%0d pulses=%0d expected 0/0", cnt_x1, n_up_x1 + n_dn_x1 - b1); end
    n_vec++; if (cnt_x4 !== 8'd2) begin n_miss++; $display("FAIL half_x4: got %0d expected 2", cnt_x4); end
  endtask

  task automatic test_load_collide();
    int b1, b4;
    b1 = n_dn_x1; b4 = n_dn_x4;
    phase(2'b01, 10); phase(2'b00, 10); phase(2'b10, 10);
    enc_a = 1'b1; enc_b = 1'b1;
    repeat (6) @(negedge clk);
    load = 1'b1; load_val = 8'd25;
    @(negedge clk);
    load = 1'b0;
    n_vec++; if ({sup_x1, sdn_x1, cnt_x1, dir_x1} !== {2'b00, 8'd19, 1'b0}) begin
      n_miss++; $display("FAIL load_step: got up=%b dn=%b cnt=%0d dir=%b expected 0 0 19 0", sup_x1, sdn_x1, cnt_x1, dir_x1); end
    repeat (9) @(negedge clk);
    n_vec++; if (n_dn_x1 - b1 !== 0) begin n_miss++; $display("FAIL load_suppress: got %0d expected 0", n_dn_x1 - b1); end
    n_vec++; if ({cnt_x4, 8'(n_dn_x4 - b4)} !== {8'd19, 8'd3}) begin
      n_miss++; $display("FAIL load_x4: got cnt=%0d dn=%0d expected 19/3", cnt_x4, n_dn_x4 - b4); end
`ifdef QUAD_ENC_ERR_CNT_EN
    n_vec++; if (ecnt_x1 !== 8'd1) begin n_miss++; $display("FAIL ecnt_load: got %0d expected 1", ecnt_x1); end
`endif
    clr = 1'b1; load = 1'b1; load_val = 8'd5;
    @(negedge clk);
    clr = 1'b0; load = 1'b0;
    n_vec++; if ({cnt_x1, cnt_x4} !== 16'd0) begin
      n_miss++; $display("FAIL clr_load: got %0d/%0d expected 0/0", cnt_x1, cnt_x4); end
`ifdef QUAD_ENC_ERR_CNT_EN
    n_vec++; if (ecnt_x1 !== 8'd0) begin n_miss++; $display("FAIL ecnt_clr: got %0d expected 0", ecnt_x1); end
`endif
    load = 1'b1; load_val = 8'd20;
    @(negedge clk);
    n_vec++; if (cnt_x1 !== 8'd19) begin n_miss++; $display("FAIL load_20: got %0d expected 19", cnt_x1); end
    load_val = 8'd7;
    @(negedge clk);
    load = 1'b0;
    n_vec++; if (cnt_x1 !== 8'd7) begin n_miss++; $display("FAIL load_7: got %0d expected 7", cnt_x1); end
  endtask

  task automatic test_reset_mid();
    int b1, b4;
    phase(2'b10, 10); phase(2'b00, 5);
    rst_n = 1'b0;
    #1;
    n_vec++; if ({cnt_x1, cnt_x4} !== 16'd0) begin
      n_miss++; $display("FAIL rst_mid_cnt: got %0d/%0d expected 0/0", cnt_x1, cnt_x4); end
    n_vec++; if ({sup_x1, sdn_x1, dir_x1, err_x1} !== 4'b0010) begin
      n_miss++; $display("FAIL rst_mid_flags: got %b expected 0010", {sup_x1, sdn_x1, dir_x1, err_x1}); end
    repeat (3) @(negedge clk);
    enc_a = 1'b1; enc_b = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    b1 = n_up_x1 + n_dn_x1 + n_err_x1;
    b4 = n_up_x4 + n_dn_x4 + n_err_x4;
    repeat (20) @(negedge clk);
    n_vec++; if (n_up_x1 + n_dn_x1 + n_err_x1 - b1 + n_up_x4 + n_dn_x4 + n_err_x4 - b4 !== 0) begin
      n_miss++; $display("FAIL rst_spurious: got %0d events expected 0", n_up_x1 + n_dn_x1 + n_err_x1 - b1 + n_up_x4 + n_dn_x4 + n_err_x4 - b4); end
    fwd_detent();
    n_vec++; if ({cnt_x1, cnt_x4} !== {8'd1, 8'd4}) begin
      n_miss++; $display("FAIL rst_resume: got %0d/%0d expected 1/4", cnt_x1, cnt_x4); end
  endtask

  initial begin
    test_reset();
    test_single_detent();
    test_wrap();
    test_glitch();
    test_illegal();
    test_x4();
    test_load_collide();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
